// File: rtl/peak_detector.sv
// Pulse-height analyser: finds threshold-crossing pulses in the shaped filter stream and
// emits each pulse's peak amplitude and peak timestamp over a valid/ready handshake.
module peak_detector #(
  parameter int unsigned SIZE_FILTER_DATA = 16,
  parameter int unsigned TS_WIDTH         = 32,
  parameter int unsigned MIN_WIDTH        = 3,
  parameter int unsigned MAX_WIDTH        = 64,
  parameter int unsigned HOLDOFF          = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  input  logic                               enable,
  output logic                               ev_valid,
  input  logic                               ev_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] ev_amp,
  output logic        [TS_WIDTH-1:0]         ev_time,
  output logic                               ev_pileup,
  output logic        [15:0]                 drop_count
);

  localparam int unsigned WW = $clog2(MAX_WIDTH + 1);
  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {StIdle, StRise, StWaitLow, StHold} state_e;

  state_e                             state_q, state_d;
  logic signed [SIZE_FILTER_DATA-1:0] x_q;
  logic        [TS_WIDTH-1:0]         ts_q;
  logic signed [SIZE_FILTER_DATA-1:0] max_q, max_d;
  logic        [TS_WIDTH-1:0]         max_t_q, max_t_d;
  logic        [WW-1:0]               width_q, width_d;
  logic        [HW-1:0]               hold_q, hold_d;

  logic                               above;
  logic                               emit;
  logic                               emit_pileup;
  logic signed [SIZE_FILTER_DATA-1:0] emit_amp;
  logic        [TS_WIDTH-1:0]         emit_time;

  assign above = x_q > threshold;

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    max_t_d     = max_t_q;
    width_d     = width_q;
    hold_d      = hold_q;
    emit        = 1'b0;
    emit_pileup = 1'b0;
    emit_amp    = max_q;
    emit_time   = max_t_q;
    unique case (state_q)
      StIdle: begin
        if (enable && above) begin
          max_d   = x_q;
          max_t_d = ts_q;
          width_d = WW'(1);
          state_d = StRise;
        end
      end
      StRise: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (above) begin
          // Strict compare: on a tie the earlier sample keeps the timestamp.
          if (x_q > max_q) begin
            max_d   = x_q;
            max_t_d = ts_q;
          end
          width_d = width_q + WW'(1);
          if (width_d == WW'(MAX_WIDTH)) begin
            emit        = 1'b1;
            emit_pileup = 1'b1;
            emit_amp    = max_d;
            emit_time   = max_t_d;
            state_d     = StWaitLow;
          end
        end else if (width_q >= WW'(MIN_WIDTH)) begin
          emit    = 1'b1;
          hold_d  = '0;
          state_d = StHold;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitLow: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (!above) begin
          hold_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (!enable || hold_q == HW'(HOLDOFF - 1)) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      ts_q    <= '0;
      max_q   <= '0;
      max_t_q <= '0;
      width_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= filter_data;
      ts_q    <= ts_q + TS_WIDTH'(1);
      max_q   <= max_d;
      max_t_q <= max_t_d;
      width_q <= width_d;
      hold_q  <= hold_d;
    end
  end

  // Output slot: a new event may only replace one that is leaving this same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_valid   <= 1'b0;
      ev_amp     <= '0;
      ev_time    <= '0;
      ev_pileup  <= 1'b0;
      drop_count <= '0;
    end else if (emit) begin
      if (!ev_valid || ev_ready) begin
        ev_valid  <= 1'b1;
        ev_amp    <= emit_amp;
        ev_time   <= emit_time;
        ev_pileup <= emit_pileup;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peak_detector.sv
// Directed bench for peak_detector; TS_WIDTH is 8 so timestamp wrap is reachable.
module tb_peak_detector;

  localparam int unsigned W   = 16;
  localparam int unsigned TSW = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 enable = 1'b1;
  logic                 ev_ready = 1'b1;
  logic signed [W-1:0]  filter_data = '0;
  logic signed [W-1:0]  threshold = 16'sd100;
  logic                 ev_valid;
  logic signed [W-1:0]  ev_amp;
  logic [TSW-1:0]       ev_time;
  logic                 ev_pileup;
  logic [15:0]          drop_count;

  int passed = 0;
  int total  = 0;
  int ecount = 0;
  int xfers  = 0;
  logic signed [W-1:0] last_amp = '0;

  always #5 clk = ~clk;

  peak_detector #(
    .SIZE_FILTER_DATA(W),
    .TS_WIDTH        (TSW),
    .MIN_WIDTH       (3),
    .MAX_WIDTH       (64),
    .HOLDOFF         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .filter_data(filter_data),
    .threshold  (threshold),
    .enable     (enable),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_amp     (ev_amp),
    .ev_time    (ev_time),
    .ev_pileup  (ev_pileup),
    .drop_count (drop_count)
  );

  // Edges since reset release; a sample driven now sits in x when this reads ecount+1.
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  always @(posedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      xfers    <= xfers + 1;
      last_amp <= ev_amp;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [W-1:0] s);
    filter_data = s;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++; if (ev_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", ev_valid); else passed++;
    total++; if (ev_amp !== 16'sd0) $display("FAIL reset_amp got=%0d want=0", ev_amp); else passed++;
    total++; if (ev_time !== 8'd0) $display("FAIL reset_time got=%0d want=0", ev_time); else passed++;
    total++; if (ev_pileup !== 1'b0) $display("FAIL reset_pileup got=%0b want=0", ev_pileup); else passed++;
    total++; if (drop_count !== 16'd0) $display("FAIL reset_drop got=%0d want=0", drop_count); else passed++;
    step();
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_single_pulse();
    logic signed [W-1:0] s [7] = '{16'sd0, 16'sd150, 16'sd300, 16'sd450, 16'sd300, 16'sd150, 16'sd50};
    logic [TSW-1:0] ts_peak = '0;
    int x0 = xfers;
    for (int i = 0; i < 7; i++) begin
      filter_data = s[i];
      if (i == 3) ts_peak = TSW'(ecount + 1);
      step();
    end
    total++; if (ev_valid !== 1'b0) $display("FAIL single_early got=%0b want=0", ev_valid); else passed++;
    drive('0);
    total++; if (ev_valid !== 1'b1) $display("FAIL single_valid got=%0b want=1", ev_valid); else passed++;
    total++; if (ev_amp !== 16'sd450) $display("FAIL single_amp got=%0d want=450", ev_amp); else passed++;
    total++; if (ev_time !== ts_peak) $display("FAIL single_time got=%0d want=%0d", ev_time, ts_peak); else passed++;
    total++; if (ev_pileup !== 1'b0) $display("FAIL single_pileup got=%0b want=0", ev_pileup); else passed++;
    drive('0);
    total++; if (ev_valid !== 1'b0) $display("FAIL single_one_cycle got=%0b want=0", ev_valid); else passed++;
    idle(12);
    total++; if (xfers - x0 !== 1) $display("FAIL single_count got=%0d want=1", xfers - x0); else passed++;
  endtask

  task automatic test_short_pulse();
    int x0 = xfers;
    drive(16'sd200);
    drive(16'sd200);
    idle(12);
    total++; if (xfers - x0 !== 0) $display("FAIL short_count got=%0d want=0", xfers - x0); else passed++;
    total++; if (drop_count !== 16'd0) $display("FAIL short_drop got=%0d want=0", drop_count); else passed++;
    // A following valid pulse proves the FSM went back to idle.
    drive(16'sd150);
    drive(16'sd250);
    drive(16'sd150);
    drive('0);
    step();
    total++; if (ev_valid !== 1'b1) $display("FAIL short_next_valid got=%0b want=1", ev_valid); else passed++;
    total++; if (ev_amp !== 16'sd250) $display("FAIL short_next_amp got=%0d want=250", ev_amp); else passed++;
    idle(12);
  endtask

  task automatic test_pileup();
    int x0 = xfers;
    int hit = -1;
    logic [TSW-1:0] first_ts = TSW'(ecount + 1);
    logic signed [W-1:0] amp_c = '0;
    logic [TSW-1:0] t_c = '0;
    logic p_c = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      drive(16'sd500);
      if (ev_valid && hit < 0) begin
        hit   = i;
        amp_c = ev_amp;
        t_c   = ev_time;
        p_c   = ev_pileup;
      end
    end
    total++; if (hit !== 65) $display("FAIL pileup_latency got=%0d want=65", hit); else passed++;
    total++; if (amp_c !== 16'sd500) $display("FAIL pileup_amp got=%0d want=500", amp_c); else passed++;
    total++; if (p_c !== 1'b1) $display("FAIL pileup_flag got=%0b want=1", p_c); else passed++;
    total++; if (t_c !== first_ts) $display("FAIL pileup_time got=%0d want=%0d", t_c, first_ts); else passed++;
    idle(20);
    total++; if (xfers - x0 !== 1) $display("FAIL pileup_count got=%0d want=1", xfers - x0); else passed++;
  endtask

  task automatic test_back_pressure();
    int x0 = xfers;
    logic [TSW-1:0] t1 = '0;
    logic signed [W-1:0] amps [3] = '{16'sd300, 16'sd400, 16'sd500};
    ev_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drive(16'sd150);
      if (p == 0) t1 = TSW'(ecount + 1);
      drive(amps[p]);
      drive(16'sd150);
      idle(17);
    end
    total++; if (ev_valid !== 1'b1) $display("FAIL bp_valid got=%0b want=1", ev_valid); else passed++;
    total++; if (ev_amp !== 16'sd300) $display("FAIL bp_amp got=%0d want=300", ev_amp); else passed++;
    total++; if (ev_time !== t1) $display("FAIL bp_time got=%0d want=%0d", ev_time, t1); else passed++;
    total++; if (drop_count !== 16'd2) $display("FAIL bp_drop got=%0d want=2", drop_count); else passed++;
    ev_ready = 1'b1;
    step();
    total++; if (ev_valid !== 1'b0) $display("FAIL bp_release got=%0b want=0", ev_valid); else passed++;
    total++; if (last_amp !== 16'sd300) $display("FAIL bp_xfer_amp got=%0d want=300", last_amp); else passed++;
    total++; if (xfers - x0 !== 1) $display("FAIL bp_count got=%0d want=1", xfers - x0); else passed++;
  endtask

  task automatic test_back_to_back();
    int x0;
    ev_ready = 1'b0;
    drive(16'sd150);
    drive(16'sd600);
    drive(16'sd150);
    idle(12);
    total++; if (ev_amp !== 16'sd600) $display("FAIL b2b_pending got=%0d want=600", ev_amp); else passed++;
    x0 = xfers;
    drive(16'sd150);
    drive(16'sd700);
    drive(16'sd150);
    drive('0);
    ev_ready = 1'b1;
    step();
    total++; if (ev_valid !== 1'b1) $display("FAIL b2b_valid got=%0b want=1", ev_valid); else passed++;
    total++; if (ev_amp !== 16'sd700) $display("FAIL b2b_amp got=%0d want=700", ev_amp); else passed++;
    total++; if (last_amp !== 16'sd600) $display("FAIL b2b_xfer_amp got=%0d want=600", last_amp); else passed++;
    total++; if (drop_count !== 16'd2) $display("FAIL b2b_drop got=%0d want=2", drop_count); else passed++;
    total++; if (xfers - x0 !== 1) $display("FAIL b2b_count got=%0d want=1", xfers - x0); else passed++;
    step();
    total++; if (ev_valid !== 1'b0) $display("FAIL b2b_drain got=%0b want=0", ev_valid); else passed++;
    idle(12);
  endtask

  task automatic test_enable();
    int x0 = xfers;
    drive(16'sd200);
    drive(16'sd300);
    enable = 1'b0;
    drive(16'sd300);
    drive(16'sd200);
    idle(2);
    enable = 1'b1;
    idle(12);
    total++; if (xfers - x0 !== 0) $display("FAIL enable_count got=%0d want=0", xfers - x0); else passed++;
    total++; if (ev_valid !== 1'b0) $display("FAIL enable_valid got=%0b want=0", ev_valid); else passed++;
  endtask

  task automatic test_reset_ts();
    int x0;
    ev_ready = 1'b0;
    drive(16'sd150);
    drive(16'sd250);
    drive(16'sd150);
    idle(12);
    total++; if (ev_valid !== 1'b1) $display("FAIL rst_pending got=%0b want=1", ev_valid); else passed++;
    x0 = xfers;
    drive(16'sd200);
    drive(16'sd900);
    filter_data = '0;
    #2 reset = 1'b1;
    #1;
    total++; if (ev_valid !== 1'b0) $display("FAIL rst_valid got=%0b want=0", ev_valid); else passed++;
    total++; if (ev_amp !== 16'sd0) $display("FAIL rst_amp got=%0d want=0", ev_amp); else passed++;
    total++; if (ev_time !== 8'd0) $display("FAIL rst_time got=%0d want=0", ev_time); else passed++;
    total++; if (drop_count !== 16'd0) $display("FAIL rst_drop got=%0d want=0", drop_count); else passed++;
    #1 reset = 1'b0;
    ev_ready = 1'b1;
    // First sample after reset is registered with ts=1, so the 250 peak lands at ts=2.
    drive(16'sd150);
    drive(16'sd250);
    drive(16'sd150);
    drive('0);
    step();
    total++; if (ev_amp !== 16'sd250) $display("FAIL rst_next_amp got=%0d want=250", ev_amp); else passed++;
    total++; if (ev_time !== 8'd2) $display("FAIL rst_ts_restart got=%0d want=2", ev_time); else passed++;
    total++; if (xfers - x0 !== 0) $display("FAIL rst_no_xfer got=%0d want=0", xfers - x0); else passed++;
    idle(12);
    for (int i = 0; i < 300 && ecount != 253; i++) drive('0);
    drive(16'sd150);
    drive(16'sd300);
    drive(16'sd350);
    drive(16'sd150);
    drive('0);
    step();
    total++; if (ev_amp !== 16'sd350) $display("FAIL wrap_amp got=%0d want=350", ev_amp); else passed++;
    total++; if (ev_time !== 8'd0) $display("FAIL wrap_time got=%0d want=0", ev_time); else passed++;
    idle(5);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_short_pulse();
    test_pileup();
    test_back_pressure();
    test_back_to_back();
    test_enable();
    test_reset_ts();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/peak_detector.md
# peak_detector

Pulse-height analyser that sits directly downstream of the trapezoidal shaping filter. It consumes the filter's output word every clock, detects pulses that cross a programmable threshold, and captures each pulse's maximum amplitude and the timestamp of that maximum. Each event is delivered over a valid/ready handshake to the event buffer. Pulses that are too long are flagged as pile-up, and events lost to back-pressure are counted.

## Interface
- SIZE_FILTER_DATA, 16, width of filter samples, threshold and amplitude; two's complement.
- TS_WIDTH, 32, timestamp counter width.
- MIN_WIDTH, 3, minimum number of above-threshold samples for a valid pulse.
- MAX_WIDTH, 64, above-threshold sample count at which the pulse is declared pile-up.
- HOLDOFF, 8, dead-time cycles after each pulse ends.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- filter_data  in  SIZE_FILTER_DATA  filter output sample, signed, one per clock.
- threshold  in  SIZE_FILTER_DATA  signed trigger level; quasi-static.
- enable  in  1  detection enable.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts event.
- ev_amp  out  SIZE_FILTER_DATA  peak amplitude.
- ev_time  out  TS_WIDTH  timestamp of the peak sample.
- ev_pileup  out  1  event was terminated by MAX_WIDTH.
- drop_count  out  16  events lost to back-pressure; saturating.

## Operation
- Input stage: filter_data is registered into x each clock. All comparisons use x versus threshold, signed.
- ts counter: 0 at reset, +1 every clock, wraps modulo 2^TS_WIDTH. ts_x is the ts value in the cycle x holds a sample.
- FSM states: IDLE, RISE, WAIT_LOW, HOLD.
- IDLE:
  - Condition: enable && x > threshold.
  - Action: max<=x, max_t<=ts_x, width<=1, go to RISE.
- RISE, x > threshold:
  - If x > max (strict; ties keep the earlier sample): max<=x, max_t<=ts_x.
  - width increments.
  - If width reaches MAX_WIDTH: emit (max, max_t, pileup=1) and go to WAIT_LOW.
- RISE, x <= threshold:
  - If width >= MIN_WIDTH: emit (max, max_t, pileup=0) and go to HOLD.
  - Otherwise: discard silently and go to IDLE.
- WAIT_LOW: stay until x <= threshold, then go to HOLD.
- HOLD:
  - Counts HOLDOFF cycles with input ignored, then goes to IDLE.
  - If x is still above threshold on return to IDLE, a new pulse starts (level trigger).
- enable low in any non-IDLE state:
  - Go to IDLE next cycle and discard the in-progress pulse.
  - Pending ev_valid and its data are unaffected.
- Emit:
  - If ev_valid==0, or ev_valid && ev_ready in the same cycle: load ev_amp/ev_time/ev_pileup and set ev_valid=1.
  - Otherwise the new event is dropped and drop_count increments, saturating at 16'hFFFF.
- Handshake:
  - Transfer occurs when ev_valid && ev_ready at a rising edge.
  - ev_valid and ev_* data are held stable until the transfer; ev_valid falls after it unless a simultaneous emit reloads it.
- Widths:
  - width counter is sized for MAX_WIDTH and never wraps.
  - max is SIZE_FILTER_DATA wide, so no arithmetic growth.

## Timing
- Reset values: ev_valid=0, ev_amp=0, ev_time=0, ev_pileup=0, drop_count=0; FSM=IDLE, x=0, ts=0.
- Reset mid-pulse or with an event pending: the event is lost and not counted.
- Input latency: a sample presented before edge E is in x after E.
- Event latency: for a normal pulse, ev_valid rises on the edge after the one that registered the first at-or-below-threshold sample.
- Pile-up latency: ev_valid rises on the edge after the one that registered the MAX_WIDTH-th above-threshold sample.
- Throughput:
  - Minimum spacing between emitted events is MIN_WIDTH+1+HOLDOFF cycles.
  - The consumer holding ev_ready=1 never causes drops.
- ts wraps: ev_time reports the raw wrapped value; no special handling.

## Test plan
- Single pulse test:
  - Stimulus: threshold=100; samples 0,150,300,450,300,150,50, then 0s; ev_ready=1.
  - Required: exactly one event with ev_amp=450, ev_time = ts of the 450 sample, ev_pileup=0; ev_valid high for 1 cycle; ev_valid rises 2 edges after the sample 50 was presented.
- Short pulse test:
  - Stimulus: threshold=100; two samples of 200, then 0.
  - Required: no event; FSM returns to IDLE; drop_count=0.
- Pile-up test:
  - Stimulus: MAX_WIDTH=64; 100 consecutive samples of 500, then 0.
  - Required: one event with ev_amp=500, ev_pileup=1, ev_time = ts of the first 500 sample (tie rule); no second event before HOLD expires.
- Back-pressure test:
  - Stimulus: ev_ready=0; three valid pulses spaced 20 cycles apart.
  - Required: the first event is held stable; drop_count=2. Raising ev_ready transfers the first event and ev_valid falls.
- Simultaneous accept and emit test:
  - Stimulus: ev_ready rises in exactly the cycle a second event is emitted.
  - Required: the first event transfers, the second loads, ev_valid stays high, drop_count unchanged.
- Reset and enable test:
  - Stimulus: assert reset asynchronously mid-RISE, and separately drop enable mid-RISE.
  - Required: all outputs clear immediately on reset; no event from the aborted pulse in either case.
  - Required: ts restarts at 0 after reset and wraps from 2^TS_WIDTH-1 to 0 (checked with TS_WIDTH=8).
